// File: rtl/hex_entry_buffer_pkg.sv
// Shared ASCII codes and FSM state encoding for the hex entry buffer.
package hex_entry_buffer_pkg;

    localparam logic [7:0]  CH_BS       = 8'h08;
    localparam logic [7:0]  CH_DEL      = 8'h7F;
    localparam logic [7:0]  CH_CR       = 8'h0D;
    localparam logic [7:0]  CH_ESC      = 8'h1B;
    localparam logic [7:0]  CH_ZERO     = 8'h30;
    localparam logic [31:0] FIELD_RESET = 32'h30303030;

    localparam logic [2:0]  FIELD_CHARS = 3'd4;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PART  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/hex_entry_buffer_classify.sv
// Combinational classifier for received bytes; lowercase hex is folded to uppercase.
module ascii_hex_classify
    import hex_entry_buffer_pkg::*;
(
    input  logic [7:0] rx_data,
    output logic       is_hex,
    output logic       is_bs,
    output logic       is_cr,
    output logic       is_esc,
    output logic [7:0] folded_char
);

    logic w_is_digit;
    logic w_is_upper;
    logic w_is_lower;

    assign w_is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign w_is_upper = (rx_data >= 8'h41) && (rx_data <= 8'h46);
    assign w_is_lower = (rx_data >= 8'h61) && (rx_data <= 8'h66);

    assign is_hex      = w_is_digit || w_is_upper || w_is_lower;
    assign is_bs       = (rx_data == CH_BS) || (rx_data == CH_DEL);
    assign is_cr       = (rx_data == CH_CR);
    assign is_esc      = (rx_data == CH_ESC);
    assign folded_char = w_is_lower ? (rx_data - 8'h20) : rx_data;

endmodule

// File: rtl/hex_entry_buffer.sv
// Four-character hex entry field with backspace, escape-clear and Enter-to-commit.
//   state   | meaning
//   S_EMPTY | no characters entered (count 0)
//   S_PART  | 1 to 3 characters entered
//   S_FULL  | 4 characters entered, further hex rejected
module hex_entry_buffer
    import hex_entry_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] buffer,
    output logic [31:0] commit_buffer,
    output logic        commit,
    output logic [2:0]  char_count,
    output logic        err
);

    state_t      r_state;
    logic [31:0] r_buffer;
    logic [31:0] r_commit_buffer;
    logic [2:0]  r_count;
    logic        r_commit;
    logic        r_err;

    state_t      w_state_nxt;
    logic [31:0] w_buffer_nxt;
    logic [31:0] w_commit_buffer_nxt;
    logic [2:0]  w_count_nxt;
    logic        w_commit_nxt;
    logic        w_err_nxt;

    logic        w_is_hex;
    logic        w_is_bs;
    logic        w_is_cr;
    logic        w_is_esc;
    logic [7:0]  w_char;

    ascii_hex_classify u_classify (
        .rx_data     (rx_data),
        .is_hex      (w_is_hex),
        .is_bs       (w_is_bs),
        .is_cr       (w_is_cr),
        .is_esc      (w_is_esc),
        .folded_char (w_char)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_EMPTY;
            r_buffer        <= FIELD_RESET;
            r_commit_buffer <= FIELD_RESET;
            r_count         <= 3'd0;
            r_commit        <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_buffer        <= w_buffer_nxt;
            r_commit_buffer <= w_commit_buffer_nxt;
            r_count         <= w_count_nxt;
            r_commit        <= w_commit_nxt;
            r_err           <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_buffer_nxt        = r_buffer;
        w_commit_buffer_nxt = r_commit_buffer;
        w_count_nxt         = r_count;
        w_commit_nxt        = 1'b0;
        w_err_nxt           = 1'b0;

        if (rx_valid) begin
            if (w_is_hex) begin
                if (r_state == S_FULL) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_buffer_nxt = {r_buffer[23:0], w_char};
                    w_count_nxt  = r_count + 3'd1;
                    w_state_nxt  = (r_count == FIELD_CHARS - 3'd1) ? S_FULL : S_PART;
                end
            end else if (w_is_bs) begin
                if (r_state == S_EMPTY) begin
                    w_err_nxt = 1'b1;
                end else begin
                    // Refill the vacated leading position with '0'.
                    w_buffer_nxt = {CH_ZERO, r_buffer[31:8]};
                    w_count_nxt  = r_count - 3'd1;
                    w_state_nxt  = (r_count == 3'd1) ? S_EMPTY : S_PART;
                end
            end else if (w_is_cr) begin
                if (r_state == S_EMPTY) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_commit_buffer_nxt = r_buffer;
                    w_commit_nxt        = 1'b1;
                    w_buffer_nxt        = FIELD_RESET;
                    w_count_nxt         = 3'd0;
                    w_state_nxt         = S_EMPTY;
                end
            end else if (w_is_esc) begin
                w_buffer_nxt = FIELD_RESET;
                w_count_nxt  = 3'd0;
                w_state_nxt  = S_EMPTY;
            end else begin
                w_err_nxt = 1'b1;
            end
        end
    end

    assign buffer        = r_buffer;
    assign commit_buffer = r_commit_buffer;
    assign commit        = r_commit;
    assign char_count    = r_count;
    assign err           = r_err;

endmodule

// File: tb/tb_hex_entry_buffer.sv
// Self-checking bench for hex_entry_buffer against a queue-based entry model.
module tb_hex_entry_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] buffer;
    logic [31:0] commit_buffer;
    logic        commit;
    logic [2:0]  char_count;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  m_q[$];
    logic [31:0] m_commit_word;
    logic        m_commit;
    logic        m_err;

    logic [7:0] hex_chars[22];

    hex_entry_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .buffer        (buffer),
        .commit_buffer (commit_buffer),
        .commit        (commit),
        .char_count    (char_count),
        .err           (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_word();
        logic [31:0] w;
        int n;
        w = 32'h30303030;
        n = m_q.size();
        for (int i = 0; i < n; i++) w[8*(n-1-i) +: 8] = m_q[i];
        return w;
    endfunction

    function automatic logic [69:0] model_all();
        return {model_word(), m_commit_word, 3'(m_q.size()), m_commit, m_err};
    endfunction

    function automatic void model_step(input logic [7:0] b);
        m_commit = 1'b0;
        m_err    = 1'b0;
        if ((b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
            if (m_q.size() < 4) m_q.push_back((b >= 8'h61) ? b - 8'h20 : b);
            else m_err = 1'b1;
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else m_err = 1'b1;
        end else if (b == 8'h0D) begin
            if (m_q.size() > 0) begin
                m_commit_word = model_word();
                m_commit = 1'b1;
                m_q.delete();
            end else m_err = 1'b1;
        end else if (b == 8'h1B) begin
            m_q.delete();
        end else begin
            m_err = 1'b1;
        end
    endfunction

    task automatic drive(input logic [7:0] b, input logic v, input logic r);
        @(negedge clk);
        rx_data  = b;
        rx_valid = v;
        rst      = r;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rst      = 1'b0;
        if (r) begin
            m_q.delete();
            m_commit_word = 32'h30303030;
            m_commit = 1'b0;
            m_err    = 1'b0;
        end else if (v) begin
            model_step(b);
        end else begin
            m_commit = 1'b0;
            m_err    = 1'b0;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) drive(s[i], 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        drive(8'h00, 1'b0, 1'b1);
        n_tests++;
        if ({buffer, commit_buffer, char_count, commit, err} !== {32'h30303030, 32'h30303030, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got %h %h cnt=%0d c=%b e=%b", buffer, commit_buffer, char_count, commit, err);
        end
    endtask

    task automatic test_entry();
        drive(8'h31, 1'b1, 1'b0);
        drive(8'h61, 1'b1, 1'b0);
        n_tests++;
        if ({buffer, char_count, err} !== {32'h30303141, 3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL entry_fold: got %h cnt=%0d e=%b want 30303141 cnt=2 e=0", buffer, char_count, err);
        end
        drive(8'h1B, 1'b1, 1'b0);
        send_str("1234");
        n_tests++;
        if ({buffer, char_count, err} !== {32'h31323334, 3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL entry_full: got %h cnt=%0d e=%b want 31323334 cnt=4 e=0", buffer, char_count, err);
        end
        drive(8'h35, 1'b1, 1'b0);
        n_tests++;
        if ({buffer, char_count, err} !== {32'h31323334, 3'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL overflow_err: got %h cnt=%0d e=%b want 31323334 cnt=4 e=1", buffer, char_count, err);
        end
        drive(8'h00, 1'b0, 1'b0);
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_one_cycle: got e=%b want 0", err);
        end
    endtask

    task automatic test_backspace();
        drive(8'h1B, 1'b1, 1'b0);
        send_str("ABC");
        drive(8'h08, 1'b1, 1'b0);
        drive(8'h7F, 1'b1, 1'b0);
        n_tests++;
        if ({buffer, char_count} !== {32'h30303041, 3'd1}) begin
            n_fail++;
            $display("FAIL bs_partial: got %h cnt=%0d want 30303041 cnt=1", buffer, char_count);
        end
        drive(8'h08, 1'b1, 1'b0);
        n_tests++;
        if ({buffer, char_count, err} !== {32'h30303030, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL bs_to_empty: got %h cnt=%0d e=%b want 30303030 cnt=0 e=0", buffer, char_count, err);
        end
        drive(8'h08, 1'b1, 1'b0);
        n_tests++;
        if ({char_count, err} !== {3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL bs_empty_err: got cnt=%0d e=%b want cnt=0 e=1", char_count, err);
        end
    endtask

    task automatic test_commit();
        send_str("F00D");
        drive(8'h0D, 1'b1, 1'b0);
        n_tests++;
        if ({commit, err, commit_buffer, buffer, char_count} !== {1'b1, 1'b0, 32'h46303044, 32'h30303030, 3'd0}) begin
            n_fail++;
            $display("FAIL commit: got c=%b e=%b cb=%h buf=%h cnt=%0d want c=1 e=0 cb=46303044 buf=30303030 cnt=0",
                     commit, err, commit_buffer, buffer, char_count);
        end
        drive(8'h0D, 1'b1, 1'b0);
        n_tests++;
        if ({commit, err, commit_buffer} !== {1'b0, 1'b1, 32'h46303044}) begin
            n_fail++;
            $display("FAIL cr_empty: got c=%b e=%b cb=%h want c=0 e=1 cb=46303044", commit, err, commit_buffer);
        end
        send_str("12");
        drive(8'h1B, 1'b1, 1'b0);
        n_tests++;
        if ({buffer, char_count, err} !== {32'h30303030, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL esc_clear: got %h cnt=%0d e=%b want 30303030 cnt=0 e=0", buffer, char_count, err);
        end
        drive(8'h47, 1'b1, 1'b0);
        n_tests++;
        if ({err, buffer, commit_buffer} !== {1'b1, 32'h30303030, 32'h46303044}) begin
            n_fail++;
            $display("FAIL other_err: got e=%b buf=%h cb=%h want e=1 buf=30303030 cb=46303044", err, buffer, commit_buffer);
        end
    endtask

    task automatic test_reset_collision();
        drive(8'h39, 1'b1, 1'b0);
        drive(8'h38, 1'b1, 1'b1);
        n_tests++;
        if ({buffer, commit_buffer, char_count, commit, err} !== {32'h30303030, 32'h30303030, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_collision: got %h %h cnt=%0d c=%b e=%b", buffer, commit_buffer, char_count, commit, err);
        end
    endtask

    task automatic test_back_to_back_random();
        logic [7:0] b;
        logic       v;
        int         sel;
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 11);
            v   = 1'b1;
            case (sel)
                0, 1, 2, 3, 4: b = hex_chars[$urandom_range(0, 21)];
                5:             b = ($urandom_range(0, 1) == 0) ? 8'h08 : 8'h7F;
                6:             b = 8'h0D;
                7:             b = 8'h1B;
                8, 9:          b = 8'($urandom_range(0, 255));
                default: begin
                    b = 8'($urandom_range(0, 255));
                    v = 1'b0;
                end
            endcase
            drive(b, v, 1'b0);
            n_tests++;
            if ({buffer, commit_buffer, char_count, commit, err} !== model_all() || (commit && err)) begin
                n_fail++;
                $display("FAIL random[%0d] byte=%h v=%b: got %h %h cnt=%0d c=%b e=%b want %h %h cnt=%0d c=%b e=%b",
                         i, b, v, buffer, commit_buffer, char_count, commit, err,
                         model_word(), m_commit_word, m_q.size(), m_commit, m_err);
            end
        end
    endtask

    initial begin
        string hs;
        hs = "0123456789ABCDEFabcdef";
        for (int i = 0; i < 22; i++) hex_chars[i] = hs[i];
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        m_commit_word = 32'h30303030;
        m_commit = 1'b0;
        m_err    = 1'b0;

        test_reset();
        test_entry();
        test_backspace();
        test_commit();
        test_reset_collision();
        test_back_to_back_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
